// File: rtl/vram_brush_controller_pkg.sv
// Shared definitions for the VRAM write-side controller: controller states,
// default display geometry and the frame-buffer length helper.
package vram_brush_controller_pkg;

    localparam int DEF_DISPLAY_WIDTH  = 240;
    localparam int DEF_DISPLAY_HEIGHT = 320;
    localparam int VRAM_L             = DEF_DISPLAY_WIDTH * DEF_DISPLAY_HEIGHT;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        DRAW  = 2'd2
    } vram_ctrl_state_t;

    // Number of pixels in a frame buffer of the given geometry
    function automatic int vram_length(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/vram_brush_controller_brush_scanner.sv
// Raster scanner for a square brush. Walks offsets dy=-r..r (outer) and
// dx=-r..r (inner), one per step, and flags whether the pixel at
// centre+offset lands on the display.
module brush_scanner
    import vram_brush_controller_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = DEF_DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = DEF_DISPLAY_HEIGHT,
    parameter int COORD_W        = 9,
    parameter int BRUSH_MAX_R    = 7
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               step,
    input  logic [COORD_W-1:0]                 cx,
    input  logic [COORD_W-1:0]                 cy,
    input  logic [$clog2(BRUSH_MAX_R+1)-1:0]   r,
    output logic signed [COORD_W:0]            dx,
    output logic signed [COORD_W:0]            dy,
    output logic                               in_bounds,
    output logic                               done
);

    localparam int R_W = $clog2(BRUSH_MAX_R + 1);
    localparam int I_W = $clog2(2 * BRUSH_MAX_R + 1);
    localparam int S_W = COORD_W + 1;
    localparam logic signed [S_W-1:0] W_S = S_W'(DISPLAY_WIDTH);
    localparam logic signed [S_W-1:0] H_S = S_W'(DISPLAY_HEIGHT);

    logic [I_W-1:0]          ix;
    logic [I_W-1:0]          iy;
    logic [I_W-1:0]          last_idx;
    logic signed [S_W-1:0]   r_s;
    logic signed [S_W-1:0]   px_s;
    logic signed [S_W-1:0]   py_s;

    // Counters run 0..2r; the signed offset is the counter minus r
    always_comb begin
        last_idx  = I_W'({r, 1'b0});
        r_s       = S_W'(r);
        dx        = S_W'(ix) - r_s;
        dy        = S_W'(iy) - r_s;
        px_s      = S_W'(cx) + dx;
        py_s      = S_W'(cy) + dy;
        in_bounds = !px_s[S_W-1] && (px_s < W_S) && !py_s[S_W-1] && (py_s < H_S);
        done      = (ix == last_idx) && (iy == last_idx);
    end

    // Row-major advance of the offset counters; start rewinds to the top-left corner
    always_ff @(posedge clk) begin
        if (!rst) begin
            ix <= '0;
            iy <= '0;
        end else if (start) begin
            ix <= '0;
            iy <= '0;
        end else if (step) begin
            if (ix == last_idx) begin
                ix <= '0;
                iy <= iy + 1'b1;
            end else begin
                ix <= ix + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_brush_controller.sv
// VRAM write-side controller: clears the frame buffer to a background colour,
// then paints a clipped square brush at each new touch point.
module vram_brush_controller
    import vram_brush_controller_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = DEF_DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = DEF_DISPLAY_HEIGHT,
    parameter int VRAM_W         = 16,
    parameter int BRUSH_MAX_R    = 7,
    parameter int COORD_W        = 9,
    parameter int ADDR_W         = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               touch_valid,
    input  logic [COORD_W-1:0]                 touch_x,
    input  logic [COORD_W-1:0]                 touch_y,
    input  logic [VRAM_W-1:0]                  brush_color,
    input  logic [$clog2(BRUSH_MAX_R+1)-1:0]   brush_r,
    input  logic [VRAM_W-1:0]                  bg_color,
    input  logic                               clear_req,
    output logic                               vram_wr_ena,
    output logic [ADDR_W-1:0]                  vram_wr_addr,
    output logic [VRAM_W-1:0]                  vram_wr_data,
    output logic                               busy,
    output logic                               clearing
);

    localparam int R_W      = $clog2(BRUSH_MAX_R + 1);
    localparam int S_W      = COORD_W + 1;
    localparam int VRAM_LEN = vram_length(DISPLAY_WIDTH, DISPLAY_HEIGHT);
    localparam logic [R_W-1:0]    R_MAX     = R_W'(BRUSH_MAX_R);
    localparam logic [S_W-1:0]    X_LIM     = S_W'(DISPLAY_WIDTH);
    localparam logic [S_W-1:0]    Y_LIM     = S_W'(DISPLAY_HEIGHT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VRAM_LEN - 1);
    localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(DISPLAY_WIDTH);

    vram_ctrl_state_t        state;
    logic [ADDR_W-1:0]       clr_cnt;
    logic [VRAM_W-1:0]       bg_lat;
    logic                    pending_clear;

    // The last accepted point doubles as the parameter set of the brush being drawn
    logic                    last_valid;
    logic [COORD_W-1:0]      last_x;
    logic [COORD_W-1:0]      last_y;
    logic [VRAM_W-1:0]       last_color;
    logic [R_W-1:0]          last_r;

    logic [R_W-1:0]          r_sat;
    logic                    touch_in_range;
    logic                    touch_is_new;
    logic                    scan_start;
    logic                    scan_step;
    logic signed [S_W-1:0]   scan_dx;
    logic signed [S_W-1:0]   scan_dy;
    logic                    scan_in_bounds;
    logic                    scan_done;
    logic [COORD_W-1:0]      pix_x;
    logic [COORD_W-1:0]      pix_y;
    logic [ADDR_W-1:0]       pix_addr;

    brush_scanner #(
        .DISPLAY_WIDTH  (DISPLAY_WIDTH),
        .DISPLAY_HEIGHT (DISPLAY_HEIGHT),
        .COORD_W        (COORD_W),
        .BRUSH_MAX_R    (BRUSH_MAX_R)
    ) u_scanner (
        .clk       (clk),
        .rst       (rst),
        .start     (scan_start),
        .step      (scan_step),
        .cx        (last_x),
        .cy        (last_y),
        .r         (last_r),
        .dx        (scan_dx),
        .dy        (scan_dy),
        .in_bounds (scan_in_bounds),
        .done      (scan_done)
    );

    // Touch qualification, radius saturation and pixel address of the current brush offset
    always_comb begin
        r_sat          = (brush_r > R_MAX) ? R_MAX : brush_r;
        touch_in_range = ({1'b0, touch_x} < X_LIM) && ({1'b0, touch_y} < Y_LIM);
        touch_is_new   = !last_valid || (touch_x != last_x) || (touch_y != last_y) ||
                         (brush_color != last_color) || (r_sat != last_r);
        scan_start     = (state == IDLE);
        scan_step      = (state == DRAW);
        pix_x          = COORD_W'(S_W'(last_x) + scan_dx);
        pix_y          = COORD_W'(S_W'(last_y) + scan_dy);
        pix_addr       = ADDR_W'(pix_y) * ROW_PITCH + ADDR_W'(pix_x);
    end

    // Controller FSM with registered write port and status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= CLEAR;
            clr_cnt       <= '0;
            bg_lat        <= '0;
            pending_clear <= 1'b0;
            last_valid    <= 1'b0;
            last_x        <= '0;
            last_y        <= '0;
            last_color    <= '0;
            last_r        <= '0;
            vram_wr_ena   <= 1'b0;
            vram_wr_addr  <= '0;
            vram_wr_data  <= '0;
            busy          <= 1'b1;
            clearing      <= 1'b1;
        end else begin
            unique case (state)
                CLEAR: begin
                    vram_wr_ena  <= 1'b1;
                    vram_wr_addr <= clr_cnt;
                    vram_wr_data <= (clr_cnt == '0) ? bg_color : bg_lat;
                    busy         <= 1'b1;
                    clearing     <= 1'b1;
                    if (clr_cnt == '0) begin
                        bg_lat <= bg_color;
                    end
                    if (clr_cnt == LAST_ADDR) begin
                        state      <= IDLE;
                        clr_cnt    <= '0;
                        last_valid <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    vram_wr_ena <= 1'b0;
                    busy        <= 1'b0;
                    clearing    <= 1'b0;
                    if (clear_req || pending_clear) begin
                        state         <= CLEAR;
                        clr_cnt       <= '0;
                        pending_clear <= 1'b0;
                    end else if (touch_valid && touch_in_range && touch_is_new) begin
                        state      <= DRAW;
                        last_valid <= 1'b1;
                        last_x     <= touch_x;
                        last_y     <= touch_y;
                        last_color <= brush_color;
                        last_r     <= r_sat;
                    end
                end
                DRAW: begin
                    vram_wr_ena  <= scan_in_bounds;
                    vram_wr_addr <= pix_addr;
                    vram_wr_data <= last_color;
                    busy         <= 1'b1;
                    clearing     <= 1'b0;
                    if (clear_req) begin
                        pending_clear <= 1'b1;
                    end
                    if (scan_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_brush_controller.sv
// Bench for vram_brush_controller on a 240x40 display so each full clear is short.
// A queue-based model predicts every output cycle; directed phases add literal checks.
module tb_vram_brush_controller;

    localparam int W      = 240;
    localparam int H      = 40;
    localparam int L      = W * H;
    localparam int ADDR_W = $clog2(L);

    typedef struct packed {
        logic              ena;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
        logic              busy;
        logic              clearing;
    } out_t;

    typedef enum {JOB_IDLE, JOB_CLEAR, JOB_DRAW} job_t;

    logic              clk;
    logic              rst;
    logic              touch_valid;
    logic [8:0]        touch_x;
    logic [8:0]        touch_y;
    logic [15:0]       brush_color;
    logic [2:0]        brush_r;
    logic [15:0]       bg_color;
    logic              clear_req;
    logic              vram_wr_ena;
    logic [ADDR_W-1:0] vram_wr_addr;
    logic [15:0]       vram_wr_data;
    logic              busy;
    logic              clearing;

    int   errors = 0;
    int   checks = 0;
    out_t trace[$];
    logic [15:0] cur_bg = 16'h0000;

    vram_brush_controller #(
        .DISPLAY_WIDTH  (W),
        .DISPLAY_HEIGHT (H),
        .VRAM_W         (16),
        .BRUSH_MAX_R    (7),
        .COORD_W        (9),
        .ADDR_W         (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .touch_valid  (touch_valid),
        .touch_x      (touch_x),
        .touch_y      (touch_y),
        .brush_color  (brush_color),
        .brush_r      (brush_r),
        .bg_color     (bg_color),
        .clear_req    (clear_req),
        .vram_wr_ena  (vram_wr_ena),
        .vram_wr_addr (vram_wr_addr),
        .vram_wr_data (vram_wr_data),
        .busy         (busy),
        .clearing     (clearing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value against its expectation and tally the result
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Address and data only matter when the strobe is high
    function automatic logic [63:0] pack(input out_t o);
        return {o.ena, o.busy, o.clearing,
                (o.ena ? o.addr : {ADDR_W{1'b0}}), (o.ena ? o.data : 16'h0000)};
    endfunction

    // Behavioural model: a clear is a run of L writes, a stroke is a precomputed pixel list
    job_t        job = JOB_CLEAR;
    int          clr_addr = 0;
    logic [15:0] m_bg = 16'h0000;
    bit          m_pend = 0;
    bit          m_last_valid = 0;
    int          m_lx, m_ly, m_lr;
    logic [15:0] m_lc;
    out_t        draw_q[$];
    out_t        exp_o;
    bit          exp_valid = 0;

    always @(posedge clk) begin
        exp_valid = 1;
        if (!rst) begin
            job          = JOB_CLEAR;
            clr_addr     = 0;
            m_pend       = 0;
            m_last_valid = 0;
            draw_q.delete();
            exp_o = '{1'b0, {ADDR_W{1'b0}}, 16'h0000, 1'b1, 1'b1};
        end else begin
            case (job)
                JOB_CLEAR: begin
                    if (clr_addr == 0) m_bg = bg_color;
                    exp_o = '{1'b1, ADDR_W'(clr_addr), m_bg, 1'b1, 1'b1};
                    clr_addr++;
                    if (clr_addr == L) begin
                        job          = JOB_IDLE;
                        m_last_valid = 0;
                    end
                end
                JOB_DRAW: begin
                    exp_o = draw_q.pop_front();
                    if (clear_req) m_pend = 1;
                    if (draw_q.size() == 0) job = JOB_IDLE;
                end
                default: begin
                    exp_o = '{1'b0, {ADDR_W{1'b0}}, 16'h0000, 1'b0, 1'b0};
                    if (clear_req || m_pend) begin
                        job      = JOB_CLEAR;
                        clr_addr = 0;
                        m_pend   = 0;
                    end else if (touch_valid && int'(touch_x) < W && int'(touch_y) < H &&
                                 !(m_last_valid && m_lx == int'(touch_x) && m_ly == int'(touch_y) &&
                                   m_lc == brush_color && m_lr == ((brush_r > 7) ? 7 : int'(brush_r)))) begin
                        m_last_valid = 1;
                        m_lx = int'(touch_x);
                        m_ly = int'(touch_y);
                        m_lc = brush_color;
                        m_lr = (brush_r > 7) ? 7 : int'(brush_r);
                        for (int dy = -m_lr; dy <= m_lr; dy++) begin
                            for (int dx = -m_lr; dx <= m_lr; dx++) begin
                                if (m_lx + dx >= 0 && m_lx + dx < W && m_ly + dy >= 0 && m_ly + dy < H)
                                    draw_q.push_back('{1'b1, ADDR_W'((m_ly + dy) * W + m_lx + dx), m_lc, 1'b1, 1'b0});
                                else
                                    draw_q.push_back('{1'b0, {ADDR_W{1'b0}}, 16'h0000, 1'b1, 1'b0});
                            end
                        end
                        job = JOB_DRAW;
                    end
                end
            endcase
        end
    end

    // Every cycle: record the DUT outputs and compare them with the model
    out_t seen_o;
    always @(negedge clk) begin
        if (exp_valid) begin
            seen_o = '{vram_wr_ena, vram_wr_addr, vram_wr_data, busy, clearing};
            trace.push_back(seen_o);
            checkOutput("cycle", pack(seen_o), pack(exp_o));
        end
    end

    function automatic int countWrites();
        int n = 0;
        foreach (trace[i]) if (trace[i].ena) n++;
        return n;
    endfunction

    function automatic int countBusy();
        int n = 0;
        foreach (trace[i]) if (trace[i].busy) n++;
        return n;
    endfunction

    function automatic int writeAddr(input int k);
        int n = 0;
        foreach (trace[i]) begin
            if (trace[i].ena) begin
                if (n == k) return int'(trace[i].addr);
                n++;
            end
        end
        return -1;
    endfunction

    // Drive one cycle of inputs, then wait until the resulting outputs have been sampled
    task automatic applyStimulus(input logic rst_n, input logic tv, input logic [8:0] x,
                                 input logic [8:0] y, input logic [15:0] col,
                                 input logic [2:0] rad, input logic clr);
        rst         = rst_n;
        touch_valid = tv;
        touch_x     = x;
        touch_y     = y;
        brush_color = col;
        brush_r     = rad;
        bg_color    = cur_bg;
        clear_req   = clr;
        @(negedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, 1'b0, touch_x, touch_y, brush_color, brush_r, 1'b0);
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            idleCycles(1);
            n++;
        end
        checkOutput({name, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst         = 1'b0;
        touch_valid = 1'b0;
        touch_x     = '0;
        touch_y     = '0;
        brush_color = '0;
        brush_r     = '0;
        bg_color    = '0;
        clear_req   = 1'b0;

        // Reset values, then the power-on clear
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 9'd0, 9'd0, 16'h0, 3'd0, 1'b0);
        checkOutput("reset_state", {vram_wr_ena, busy, clearing, vram_wr_addr, vram_wr_data},
                    {1'b0, 1'b1, 1'b1, {ADDR_W{1'b0}}, 16'h0000});
        trace.delete();
        cur_bg = 16'h0000;
        idleCycles(1);
        waitIdle(L + 50, "init_clear");
        checkOutput("init_clear_writes", countWrites(), L);
        checkOutput("init_clear_first", writeAddr(0), 0);
        checkOutput("init_clear_last", writeAddr(L - 1), L - 1);
        idleCycles(5);
        checkOutput("init_clear_quiet", countWrites(), L);

        // r=0 brush held for five cycles paints once
        trace.delete();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 9'd120, 9'd20, 16'hF800, 3'd0, 1'b0);
        idleCycles(3);
        checkOutput("dedupe_writes", countWrites(), 1);
        checkOutput("dedupe_addr", writeAddr(0), 4920);
        checkOutput("dedupe_data", trace[1].data, 16'hF800);

        // r=1 brush at the origin is clipped to four pixels
        trace.delete();
        applyStimulus(1'b1, 1'b1, 9'd0, 9'd0, 16'h001F, 3'd1, 1'b0);
        idleCycles(12);
        checkOutput("corner0_cycles", countBusy(), 9);
        checkOutput("corner0_writes", countWrites(), 4);
        checkOutput("corner0_a0", writeAddr(0), 0);
        checkOutput("corner0_a1", writeAddr(1), 1);
        checkOutput("corner0_a2", writeAddr(2), 240);
        checkOutput("corner0_a3", writeAddr(3), 241);

        // r=2 brush at the far corner, then an off-screen touch
        trace.delete();
        applyStimulus(1'b1, 1'b1, 9'd239, 9'd39, 16'h07E0, 3'd2, 1'b0);
        idleCycles(28);
        checkOutput("corner1_cycles", countBusy(), 25);
        checkOutput("corner1_writes", countWrites(), 9);
        checkOutput("corner1_last", writeAddr(8), L - 1);
        trace.delete();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 9'd240, 9'd5, 16'h07E0, 3'd2, 1'b0);
        idleCycles(2);
        checkOutput("offscreen_busy", countBusy(), 0);

        // Clear requested mid-stroke waits for the stroke, then one idle cycle
        trace.delete();
        cur_bg = 16'h5555;
        applyStimulus(1'b1, 1'b1, 9'd100, 9'd20, 16'h1234, 3'd3, 1'b0);
        idleCycles(9);
        applyStimulus(1'b1, 1'b0, 9'd100, 9'd20, 16'h1234, 3'd3, 1'b1);
        idleCycles(45);
        checkOutput("pend_draw_writes", writeAddr(48), 23 * W + 103);
        checkOutput("pend_gap", {trace[49].busy, trace[49].clearing, trace[50].ena, trace[50].busy}, 4'b1000);
        checkOutput("pend_clear_start", {trace[51].ena, trace[51].clearing, trace[51].addr, trace[51].data},
                    {1'b1, 1'b1, {ADDR_W{1'b0}}, 16'h5555});
        waitIdle(L + 50, "pend_clear");

        // Reset pulse mid-stroke restarts the clear with the current background
        trace.delete();
        cur_bg = 16'hABCD;
        applyStimulus(1'b1, 1'b1, 9'd50, 9'd10, 16'h0F0F, 3'd2, 1'b0);
        idleCycles(4);
        applyStimulus(1'b0, 1'b0, 9'd50, 9'd10, 16'h0F0F, 3'd2, 1'b0);
        idleCycles(1);
        cur_bg = 16'h1111;
        idleCycles(3);
        checkOutput("rst_mid_outputs", {trace[5].ena, trace[5].busy, trace[5].clearing}, 3'b011);
        checkOutput("rst_restart", {trace[6].ena, trace[6].addr, trace[6].data},
                    {1'b1, {ADDR_W{1'b0}}, 16'hABCD});
        checkOutput("rst_bg_latched", {trace[9].addr, trace[9].data}, {ADDR_W'(3), 16'hABCD});
        waitIdle(L + 50, "rst_clear");

        // Clear and touch together: clear wins; a second request during clear is ignored
        trace.delete();
        applyStimulus(1'b1, 1'b1, 9'd60, 9'd10, 16'hFFFF, 3'd1, 1'b1);
        idleCycles(4);
        applyStimulus(1'b1, 1'b0, 9'd60, 9'd10, 16'hFFFF, 3'd1, 1'b1);
        waitIdle(L + 50, "race_clear");
        checkOutput("race_clear_start", {trace[1].ena, trace[1].clearing, trace[1].addr},
                    {1'b1, 1'b1, {ADDR_W{1'b0}}});
        checkOutput("race_no_restart", trace[5].addr, ADDR_W'(4));
        checkOutput("race_writes", countWrites(), L);
        idleCycles(3);
        checkOutput("race_no_requeue", {busy, countWrites()}, {1'b0, L});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vram_brush_controller.md
Name: vram_brush_controller

Overview:
Parametrised VRAM write-side controller for the etch-a-sketch display path. It sits between the ft6206 touch output and the block_ram write port. It clears VRAM to a programmable background colour on reset or on request. It then paints a square brush of selectable radius and colour at each new touch point, with edge clipping and duplicate-point suppression.

Parameters:
DISPLAY_WIDTH, 240, pixels per row (x range 0..W-1)
DISPLAY_HEIGHT, 320, rows (y range 0..H-1)
VRAM_W, 16, bits per pixel (ILI9341_color_t width)
BRUSH_MAX_R, 7, maximum brush radius; brush side = 2r+1
COORD_W, 9, touch coordinate width
ADDR_W, $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT), VRAM address width (17 at defaults)

Ports:
clk  in  1  system clock (all logic on posedge)
rst  in  1  synchronous active-low reset
touch_valid  in  1  touch point present this cycle
touch_x  in  COORD_W  touch column
touch_y  in  COORD_W  touch row
brush_color  in  VRAM_W  paint colour, sampled at draw start
brush_r  in  $clog2(BRUSH_MAX_R+1)  brush radius; values >BRUSH_MAX_R saturate to BRUSH_MAX_R
bg_color  in  VRAM_W  clear colour, sampled at clear start
clear_req  in  1  single-cycle clear request
vram_wr_ena  out  1  VRAM write strobe
vram_wr_addr  out  ADDR_W  write address = y*DISPLAY_WIDTH + x
vram_wr_data  out  VRAM_W  write data
busy  out  1  high in CLEAR or DRAW
clearing  out  1  high in CLEAR

Behaviour:
- One clock; reset is synchronous and active-low. While rst=0: state=CLEAR, clear counter=0, bg latch=0, pending_clear=0, last-point register invalid. Outputs: vram_wr_ena=0, vram_wr_addr=0, vram_wr_data=0, busy=1, clearing=1.
- All write-port outputs are registered. A decision in state S on edge n appears on the port after edge n.
- CLEAR:
  - bg_color is latched on the first cycle.
  - One write per cycle, addresses 0,1,...,VRAM_L-1 ascending, data = latched bg.
  - Exactly VRAM_L consecutive wr_ena cycles. After the last write: IDLE, wr_ena=0, busy=0, clearing=0, last-point invalidated.
  - clear_req during CLEAR is ignored; it neither restarts nor queues.
- IDLE:
  - Priority 1, clear_req or pending_clear: go to CLEAR with counter=0, and clear pending_clear.
  - Priority 2, touch_valid with touch_x<W, touch_y<H, and the point differs from the last-point register (compare x, y, colour, radius): latch x, y, colour, r, update last-point, go to DRAW.
  - Otherwise stay; wr_ena=0.
  - Touches with out-of-range coordinates are ignored and last-point is unchanged.
- DRAW:
  - Raster scan of offsets dy=-r..r (outer), dx=-r..r (inner), one offset per cycle. Duration is exactly (2r+1)^2 cycles.
  - Pixel (x+dx, y+dy) is computed in COORD_W+1-bit signed arithmetic. If 0<=px<W and 0<=py<H: wr_ena=1, addr=py*W+px, data=latched colour. Otherwise wr_ena=0 for that cycle (clipped, no write, still consumes the cycle).
  - Inputs changing mid-DRAW have no effect.
  - clear_req during DRAW sets pending_clear; the scan completes, then IDLE proceeds to CLEAR on the next cycle.
  - After the last offset, return to IDLE.
- Simultaneous clear_req and new touch in IDLE: clear wins; the touch is dropped.
- Reset asserted mid-CLEAR or mid-DRAW: the scan is abandoned and the block restarts at CLEAR addr 0 on release.
- Address multiply uses a constant W; the product must fit ADDR_W with no wrap.

Decomposition:
- Shared package (vram_defines): enum vram_ctrl_state_t {CLEAR, IDLE, DRAW}, plus a VRAM_L localparam.
- Colours reuse ILI9341_color_t from ili9341_defines. touch_x/y are sized to match touch_t fields.
- One sub-module, brush_scanner. Inputs: centre, r, start. Outputs: signed dx/dy offsets, in_bounds, done. It owns the raster counters and clipping.
- The top holds the FSM, latches, dedupe and address/data registers.

Test Plan:
- Reset release with bg_color=16'h0000 -> 76800 consecutive writes, addr 0..76799, data 0; then busy=0; no further writes.
- After clear, touch (120,160), r=0, colour 16'hF800 held 5 cycles -> exactly one write, addr 38520, data F800 (dedupe suppresses repeats).
- Touch (0,0), r=1 -> 9 DRAW cycles, writes only to addr 0,1,240,241 in that order.
- Touch (239,319), r=2, colour 16'h07E0 -> 25 cycles, 9 writes, the last to addr 76799; out-of-range touch (240,5) -> no DRAW, busy stays 0.
- clear_req pulsed mid-DRAW of r=3 -> all 49 offset cycles complete, then CLEAR begins one cycle later with addr 0.
- rst=0 for one cycle mid-DRAW -> wr_ena=0 and clearing=1 during reset; CLEAR restarts at addr 0 with bg latched from bg_color.
